// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : ram_fifo_ctrl
// Desc     : Stream FIFO built around a dual-port CS/OE RAM plus a 2-entry
//            read buffer. Optional sync flush input: RAM_FIFO_CTRL_FLUSH_EN.
// Revision : 1.0
// ==========================================================================
module ram_fifo_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 1 << AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RAM_FIFO_CTRL_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              cs_0,
  output logic              oe_0,
  output logic              we_0,
  output logic [AWIDTH-1:0] addr_0,
  output logic [DWIDTH-1:0] din_0,
  output logic              cs_1,
  output logic              oe_1,
  output logic              we_1,
  output logic [AWIDTH-1:0] addr_1,
  output logic [DWIDTH-1:0] din_1,
  input  logic [DWIDTH-1:0] dout_1,
  output logic [AWIDTH+1:0] level
);

  localparam logic [AWIDTH:0] c_depth = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_ram_count;
  logic              r_rd_pending;
  logic [1:0]        r_ob_count;
  logic [DWIDTH-1:0] r_ob_head;
  logic [DWIDTH-1:0] r_ob_tail;

  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic [1:0]        w_ob_count_nxt;
  logic [DWIDTH-1:0] w_ob_head_nxt;
  logic [DWIDTH-1:0] w_ob_tail_nxt;

`ifdef RAM_FIFO_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign s_ready = (r_ram_count != c_depth) & ~w_flush;
  assign w_push  = s_valid & s_ready;
  assign m_valid = (r_ob_count != 2'd0);
  assign w_pop   = m_valid & m_ready;
  assign m_data  = r_ob_head;

  // Buffer slots committed after this cycle; a new read only fits if below 2.
  assign w_occ   = {1'b0, r_ob_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_issue = (r_ram_count != '0) & (w_occ < 3'd2) & ~w_flush;

  assign cs_0   = w_push;
  assign we_0   = w_push;
  assign oe_0   = 1'b0;
  assign addr_0 = r_wptr;
  assign din_0  = s_data;

  assign cs_1   = w_issue;
  assign oe_1   = w_issue;
  assign we_1   = 1'b0;
  assign addr_1 = r_rptr;
  assign din_1  = '0;

  assign level = (AWIDTH+2)'(r_ram_count) + (AWIDTH+2)'(r_rd_pending)
               + (AWIDTH+2)'(r_ob_count);

  // Pop shifts the tail forward first, then returning read data lands in the
  // first free slot, so capture and pop in one cycle both take effect.
  always_comb begin
    w_ob_head_nxt  = r_ob_head;
    w_ob_tail_nxt  = r_ob_tail;
    w_ob_count_nxt = r_ob_count;
    if (w_pop) begin
      w_ob_head_nxt  = r_ob_tail;
      w_ob_count_nxt = r_ob_count - 2'd1;
    end
    if (r_rd_pending) begin
      if (w_ob_count_nxt == 2'd0) begin
        w_ob_head_nxt = dout_1;
      end else begin
        w_ob_tail_nxt = dout_1;
      end
      w_ob_count_nxt = w_ob_count_nxt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ram_count  <= '0;
      r_rd_pending <= 1'b0;
      r_ob_count   <= 2'd0;
      r_ob_head    <= '0;
      r_ob_tail    <= '0;
    end else if (w_flush) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ram_count  <= '0;
      r_rd_pending <= 1'b0;
      r_ob_count   <= 2'd0;
      r_ob_head    <= '0;
      r_ob_tail    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_issue})
        2'b10:   r_ram_count <= r_ram_count + 1'b1;
        2'b01:   r_ram_count <= r_ram_count - 1'b1;
        default: r_ram_count <= r_ram_count;
      endcase
      r_rd_pending <= w_issue;
      r_ob_count   <= w_ob_count_nxt;
      r_ob_head    <= w_ob_head_nxt;
      r_ob_tail    <= w_ob_tail_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : tb_ram_fifo_ctrl
// Desc     : Self-checking bench for ram_fifo_ctrl with a behavioural RAM.
// Revision : 1.0
// ==========================================================================
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data;
  logic       cs_0, oe_0, we_0, cs_1, oe_1, we_1;
  logic [3:0] addr_0, addr_1;
  logic [7:0] din_0, din_1;
  logic [7:0] dout_1 = 8'h00;
  logic [5:0] level;
`ifdef RAM_FIFO_CTRL_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DWIDTH(8), .AWIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    .flush(flush),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0), .addr_0(addr_0), .din_0(din_0),
    .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1),
    .dout_1(dout_1), .level(level)
  );

  // Behavioural true-dual-port RAM with a registered read port
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (cs_0 && we_0) mem[addr_0] <= din_0;
    if (cs_1 && oe_1 && !we_1) dout_1 <= mem[addr_1];
  end

  typedef struct {
    logic       sv;
    logic [7:0] d;
    logic       mr;
    logic       e_srdy;
    logic       e_mval;
    logic       e_cs0;
    logic [3:0] e_a0;
    logic       e_cs1;
    logic [3:0] e_a1;
    logic [5:0] e_lvl;
    logic       chk_data;
    logic [7:0] e_md;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic sv, input logic [7:0] d, input logic mr,
                              input logic srdy, input logic mval, input logic cs0,
                              input logic [3:0] a0, input logic cs1, input logic [3:0] a1,
                              input logic [5:0] lvl, input logic chk, input logic [7:0] md);
    vec_t v;
    v.sv = sv; v.d = d; v.mr = mr; v.e_srdy = srdy; v.e_mval = mval;
    v.e_cs0 = cs0; v.e_a0 = a0; v.e_cs1 = cs1; v.e_a1 = a1;
    v.e_lvl = lvl; v.chk_data = chk; v.e_md = md;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [7:0] d, input logic mr);
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0);
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    flush = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [7:0] q [$];
  int pushed, popped, first, last, w0, w1, issued, acc, gaps;
  logic       prev_stall;
  logic [7:0] prev_data;

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs",
          {s_ready, m_valid, cs_0, we_0, oe_0, cs_1, oe_1, we_1, din_1, level},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0});
    tick();
    rst_n = 1'b1;

    // Single word, then a stalled word: per-cycle strobe/latency table
    tbl[0]  = mk(1, 8'h11, 1,  1, 0, 1, 4'd0, 0, 4'd0, 6'd0, 0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 1,  1, 0, 0, 4'd1, 1, 4'd0, 6'd1, 0, 8'h00);
    tbl[2]  = mk(0, 8'h00, 1,  1, 0, 0, 4'd1, 0, 4'd1, 6'd1, 0, 8'h00);
    tbl[3]  = mk(0, 8'h00, 1,  1, 1, 0, 4'd1, 0, 4'd1, 6'd1, 1, 8'h11);
    tbl[4]  = mk(1, 8'h22, 1,  1, 0, 1, 4'd1, 0, 4'd1, 6'd0, 0, 8'h00);
    tbl[5]  = mk(0, 8'h00, 0,  1, 0, 0, 4'd2, 1, 4'd1, 6'd1, 0, 8'h00);
    tbl[6]  = mk(0, 8'h00, 0,  1, 0, 0, 4'd2, 0, 4'd2, 6'd1, 0, 8'h00);
    tbl[7]  = mk(0, 8'h00, 0,  1, 1, 0, 4'd2, 0, 4'd2, 6'd1, 1, 8'h22);
    tbl[8]  = mk(0, 8'h00, 0,  1, 1, 0, 4'd2, 0, 4'd2, 6'd1, 1, 8'h22);
    tbl[9]  = mk(0, 8'h00, 1,  1, 1, 0, 4'd2, 0, 4'd2, 6'd1, 1, 8'h22);
    tbl[10] = mk(0, 8'h00, 0,  1, 0, 0, 4'd2, 0, 4'd2, 6'd0, 0, 8'h00);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].sv, tbl[i].d, tbl[i].mr);
      @(negedge clk);
      check($sformatf("table_row%0d", i),
            {s_ready, m_valid, cs_0, we_0, addr_0, cs_1, oe_1, addr_1, level,
             (tbl[i].chk_data ? m_data : 8'h00)},
            {tbl[i].e_srdy, tbl[i].e_mval, tbl[i].e_cs0, tbl[i].e_cs0, tbl[i].e_a0,
             tbl[i].e_cs1, tbl[i].e_cs1, tbl[i].e_a1, tbl[i].e_lvl,
             (tbl[i].chk_data ? tbl[i].e_md : 8'h00)});
      tick();
    end

    // Fill to DEPTH+2 with the reader stalled, then drain
    do_reset();
    acc = 0;
    for (int c = 0; c < 25; c++) begin
      drive(1'b1, 8'(acc), 1'b0);
      @(negedge clk);
      if (s_ready) acc++;
      tick();
    end
    check("fill_accepted", 64'(acc), 64'd18);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("fill_level", 64'(level), 64'd18);
    check("fill_s_ready", 64'(s_ready), 64'd0);
    tick();
    popped = 0; first = -1; last = -1;
    for (int c = 0; c < 60 && popped < 18; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      if (m_valid) begin
        check("drain_data", 64'(m_data), 64'(popped));
        if (first < 0) first = c;
        last = c;
        popped++;
      end
      tick();
    end
    check("drain_count", 64'(popped), 64'd18);
    check("drain_no_bubbles", 64'(last - first), 64'd17);

    // Continuous streaming with pointer wrap
    do_reset();
    pushed = 0; popped = 0; first = -1; last = -1; w0 = 0; w1 = 0; issued = 0;
    for (int c = 0; c < 120 && popped < 40; c++) begin
      drive(pushed < 40, 8'h40 + 8'(pushed), 1'b1);
      @(negedge clk);
      if (cs_0 && addr_0 == 4'd0 && pushed != 0) w0++;
      if (cs_1) begin
        if (addr_1 == 4'd0 && issued != 0) w1++;
        issued++;
      end
      if (s_valid && s_ready) pushed++;
      if (m_valid) begin
        check("stream_data", 64'(m_data), 64'h40 + 64'(popped));
        if (first < 0) first = c;
        last = c;
        popped++;
      end
      tick();
    end
    check("stream_count", 64'(popped), 64'd40);
    check("stream_latency", 64'(first), 64'd3);
    check("stream_no_bubbles", 64'(last - first), 64'd39);
    check("stream_wrap_wr", 64'(w0), 64'd2);
    check("stream_wrap_rd", 64'(w1), 64'd2);

    // Random reader back-pressure against a queue scoreboard
    do_reset();
    q.delete();
    pushed = 0; popped = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 3000 && popped < 200; c++) begin
      drive(pushed < 200, 8'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check("rand_level", 64'(level), 64'(q.size()));
      if (level > 6'd18) check("rand_level_bound", 64'(level), 64'd18);
      if (q.size() < 16) check("rand_s_ready", 64'(s_ready), 64'd1);
      if (m_valid) begin
        if (q.size() == 0) check("rand_spurious_valid", 64'(m_valid), 64'd0);
        else check("rand_data", 64'(m_data), 64'(q[0]));
        if (prev_stall) check("rand_stall_hold", 64'(m_data), 64'(prev_data));
      end else if (prev_stall) begin
        check("rand_stall_valid", 64'(m_valid), 64'd1);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        pushed++;
      end
      if (m_valid && m_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        popped++;
      end
      tick();
    end
    check("rand_done", 64'(popped), 64'd200);

    // Asynchronous reset in the middle of a transfer
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'h70 + 8'(i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    tick(); tick(); tick();
    @(negedge clk);
    check("prereset_level", 64'(level), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {m_valid, s_ready, level}, {1'b0, 1'b1, 6'd0});
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'hA5, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      @(negedge clk);
      if (m_valid) begin
        check("after_reset_data", 64'(m_data), 64'hA5);
        first = c;
      end
      tick();
    end
    check("after_reset_seen", 64'(first >= 0), 64'd1);

`ifdef RAM_FIFO_CTRL_FLUSH_EN
    // Flush with a read in flight
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h50 + 8'(i), 1'b0);
      tick();
    end
    drive(1'b1, 8'h55, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 8'h66, 1'b0);
    @(negedge clk);
    check("flush_pre_level", 64'(level), 64'd5);
    check("flush_strobes", {s_ready, cs_0, cs_1}, 3'b000);
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("flush_after", {m_valid, level}, {1'b0, 6'd0});
    tick();
    @(negedge clk);
    check("flush_no_stale", {m_valid, level}, {1'b0, 6'd0});
    tick();
    drive(1'b1, 8'h3C, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    first = -1;
    for (int c = 0; c < 10 && first < 0; c++) begin
      @(negedge clk);
      if (m_valid) begin
        check("flush_next_data", 64'(m_data), 64'h3C);
        first = c;
      end
      tick();
    end
    check("flush_next_seen", 64'(first >= 0), 64'd1);
    @(negedge clk);
    check("flush_final_level", 64'(level), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Stream-to-RAM controller directly upstream of the true-dual-port CS/OE RAM.
- Turns a valid/ready write stream into port-0 write strobes and drains stored words through port-1 reads.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output buffer and presents a valid/ready read stream.
- Together with the RAM it forms a FIFO of DEPTH+2 words.

Parameters:
DWIDTH, 8, data word width; matches RAM DWIDTH
AWIDTH, 4, RAM address width; matches RAM AWIDTH
DEPTH, 1<<AWIDTH, RAM entries used; must equal RAM RDEPTH

Ports:
clk  input  1  rising-edge clock, shared with the RAM
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  write-stream data valid
s_ready  output  1  write-stream ready
s_data  input  DWIDTH  write-stream data
m_valid  output  1  read-stream data valid
m_ready  input  1  read-stream ready
m_data  output  DWIDTH  read-stream data (head of output buffer)
cs_0  output  1  RAM port-0 chip select
oe_0  output  1  RAM port-0 output enable; tied 0
we_0  output  1  RAM port-0 write enable
addr_0  output  AWIDTH  RAM port-0 address (write pointer)
din_0  output  DWIDTH  RAM port-0 write data
cs_1  output  1  RAM port-1 chip select
oe_1  output  1  RAM port-1 output enable
we_1  output  1  RAM port-1 write enable; tied 0
addr_1  output  AWIDTH  RAM port-1 address (read pointer)
din_1  output  DWIDTH  RAM port-1 write data; tied 0
dout_1  input  DWIDTH  RAM port-1 registered read data
level  output  AWIDTH+2  total words held: ram_count + rd_pending + ob_count

Behaviour:
- Reset (rst_n low, asynchronous): wptr=0, rptr=0, ram_count=0, rd_pending=0, ob_count=0, buffer data=0.
- Reset output values: s_ready=1, m_valid=0, level=0, all RAM strobes 0. Reset mid-operation discards all stored and in-flight words.
- Write side:
  - s_ready = (ram_count != DEPTH), from registered state only.
  - push = s_valid & s_ready.
  - cs_0 = we_0 = push; addr_0 = wptr; din_0 = s_data (combinational).
  - On push, wptr increments modulo DEPTH (natural AWIDTH wrap).
- Read issue:
  - pop = m_valid & m_ready.
  - issue = (ram_count != 0) & (ob_count + rd_pending - pop < 2).
  - cs_1 = oe_1 = issue; addr_1 = rptr. On issue, rptr increments modulo DEPTH.
  - rd_pending <= issue.
- A word written at edge t is first readable by an issue in the following cycle, so the RAM never sees a same-address read/write collision on a live entry.
- ram_count update: +1 on push, -1 on issue, unchanged on both.
- Capture: when rd_pending=1, dout_1 is written into the output buffer tail in that cycle.
- Output buffer: 2-entry FIFO, m_valid = (ob_count != 0). Capture and pop in the same cycle are both honoured.
- Latency: s_data accepted at edge t -> issue in cycle t+1 -> dout_1 valid t+2 -> m_valid high from t+3 (3 cycles, empty FIFO).
- Throughput: 1 word/cycle sustained on both sides when m_ready=1.
- Full: ram_count==DEPTH drops s_ready the cycle after the filling push. s_ready does not anticipate an issue in the same cycle.
- Empty: no issue; m_valid falls after the last pop.
- m_valid low: m_ready is ignored. m_data holds its value while m_valid=1 and m_ready=0.

Optional Feature:
- Macro RAM_FIFO_CTRL_FLUSH_EN.
- Defined: adds input flush (1 bit). flush=1 at a clock edge synchronously clears wptr, rptr, ram_count, rd_pending and ob_count, discarding any in-flight read data.
  - During a flush cycle, push and issue are suppressed: s_ready=0, cs_0=0, cs_1=0.
  - State after the flush edge equals the reset state.
- Not defined: no flush port; logic absent.

Test Plan:
- Push 0x11 with m_ready=1 into an empty FIFO -> cs_0/we_0 with addr_0=0 at the push; cs_1/oe_1 addr_1=0 one cycle later; m_valid=1 with m_data=0x11 three cycles after the push; level returns to 0 after the pop.
- m_ready=0, push 0x00..0x11 (18 words, DEPTH=16) -> s_ready drops after 18 accepted; level=18; the 19th word is not accepted; then m_ready=1 -> 0x00..0x11 in order, one per cycle.
- Continuous push and pop, 40 words -> no bubbles after the initial 3-cycle latency; addr_0/addr_1 wrap 15->0 twice; data order intact.
- Random m_ready toggling with continuous s_valid, 200 words -> scoreboard matches; m_data stable while stalled; ob_count never exceeds 2.
- Assert rst_n low mid-transfer with level=7 -> m_valid=0, s_ready=1, level=0 immediately; the next pushed word 0xA5 emerges first.
- With RAM_FIFO_CTRL_FLUSH_EN, flush pulse with level=5 and a read in flight -> level=0 and m_valid=0 next cycle; the stale dout_1 is not captured; next push 0x3C read back correctly.
